// File: rtl/mux_32b.sv
// mux_32b: two-input datapath selector with a combinational output
// plus a registered copy of the selected word and a select-change strobe.
//
// Parameters:
//   WIDTH     - data width of in1, in2, dataout, dataout_q
//   RESET_VAL - value of dataout_q while in reset
// Ports:
//   clk         - rising-edge clock for registered outputs
//   rst_n       - asynchronous active-low reset
//   in1         - source selected when sel=0
//   in2         - source selected when sel=1
//   sel         - source select
//   en          - capture enable (1 loads, 0 holds)
//   dataout     - combinational selected word
//   dataout_q   - registered selected word
//   sel_q       - sel captured on the last enabled edge
//   sel_changed - one-cycle strobe: enabled capture changed sel_q
module mux_32b #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] dataout,
  output logic [WIDTH-1:0] dataout_q,
  output logic             sel_q,
  output logic             sel_changed
);

  // The conditional operator merges both sources when sel is
  // unknown: agreeing bits pass through, disagreeing bits go X.
  // This never silently favours one side.
  assign dataout = sel ? in2 : in1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataout_q   <= RESET_VAL;
      sel_q       <= 1'b0;
      sel_changed <= 1'b0;
    end else if (en) begin
      dataout_q   <= dataout;
      sel_q       <= sel;
      sel_changed <= (sel != sel_q);
    end else begin
      sel_changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_32b.sv
// tb_mux_32b: directed plus randomized checks of mux_32b
// against a behavioural reference model.
module tb_mux_32b;

  logic        clk;
  logic        rst_n;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        sel;
  logic        en;
  logic [31:0] dataout;
  logic [31:0] dataout_q;
  logic        sel_q;
  logic        sel_changed;

  int vectors;
  int miscompares;

  // reference state
  logic [31:0] m_q;
  logic        m_sel;
  logic        m_chg;

  mux_32b dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in1         (in1),
    .in2         (in2),
    .sel         (sel),
    .en          (en),
    .dataout     (dataout),
    .dataout_q   (dataout_q),
    .sel_q       (sel_q),
    .sel_changed (sel_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pick(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    logic [31:0] src [2];
    src[0] = a;
    src[1] = b;
    return src[s];
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(input string tag);
    chk(tag, dataout, pick(in1, in2, sel));
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_q"}, dataout_q, m_q);
    chk({tag, "_selq"}, {31'd0, sel_q}, {31'd0, m_sel});
    chk({tag, "_chg"}, {31'd0, sel_changed}, {31'd0, m_chg});
  endtask

  // Advance one rising edge, update the model, then sample.
  task automatic tick();
    logic [31:0] d;
    logic        s;
    logic        e;
    d = pick(in1, in2, sel);
    s = sel;
    e = en;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (e) begin
        m_chg = (s != m_sel);
        m_q   = d;
        m_sel = s;
      end else begin
        m_chg = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_q   = 32'd0;
    m_sel = 1'b0;
    m_chg = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    in1   = 32'd7;
    in2   = 32'd13;
    sel   = 1'b0;
    en    = 1'b1;
    model_reset();
    #2;
    chk("rst_q", dataout_q, 32'd0);
    chk("rst_selq", {31'd0, sel_q}, 32'd0);
    chk("rst_chg", {31'd0, sel_changed}, 32'd0);
    chk("rst_comb", dataout, 32'd7);
    tick();
    chk_regs("rst_hold");
    #2 rst_n = 1'b1;

    // sel=0 selects in1
    tick();
    chk("t1_comb", dataout, 32'd7);
    chk("t1_q", dataout_q, 32'd7);
    chk("t1_selq", {31'd0, sel_q}, 32'd0);
    chk("t1_chg", {31'd0, sel_changed}, 32'd0);

    // sel 0->1
    sel = 1'b1;
    #1 chk("t2_comb", dataout, 32'd13);
    tick();
    chk("t2_q", dataout_q, 32'd13);
    chk("t2_selq", {31'd0, sel_q}, 32'd1);
    chk("t2_chg", {31'd0, sel_changed}, 32'd1);
    tick();
    chk("t2_chg_clr", {31'd0, sel_changed}, 32'd0);

    // in1 change alone with sel=1
    in1 = 32'd19;
    in2 = 32'd23;
    #1 chk("t3_comb", dataout, 32'd23);
    in1 = 32'd20;
    #1 chk("t3_in1", dataout, 32'd23);
    tick();
    chk("t3_q", dataout_q, 32'd23);
    chk_regs("t3");

    // en=0 hold
    en  = 1'b0;
    in1 = 32'd7;
    in2 = 32'd13;
    sel = 1'b0;
    #1 chk("t4_comb0", dataout, 32'd7);
    tick();
    sel = 1'b1;
    #1 chk("t4_comb1", dataout, 32'd13);
    tick();
    chk("t4_q", dataout_q, 32'd23);
    chk("t4_selq", {31'd0, sel_q}, 32'd1);
    chk("t4_chg", {31'd0, sel_changed}, 32'd0);

    // async reset mid-cycle
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_q", dataout_q, 32'd0);
    chk("t5_selq", {31'd0, sel_q}, 32'd0);
    chk("t5_chg", {31'd0, sel_changed}, 32'd0);
    chk("t5_comb", dataout, 32'd13);
    sel = 1'b1;
    en  = 1'b1;
    #1 rst_n = 1'b1;
    tick();
    chk("t5_rel_chg", {31'd0, sel_changed}, 32'd1);
    chk_regs("t5_rel");

    // walking ones
    for (int i = 0; i < 32; i++) begin
      in1 = 32'd1 << i;
      in2 = ~in1;
      sel = 1'b0;
      #1 chk_comb($sformatf("walk%0d_s0", i));
      sel = 1'b1;
      #1 chk_comb($sformatf("walk%0d_s1", i));
    end
    tick();
    chk_regs("walk");

    // randomized
    for (int n = 0; n < 300; n++) begin
      in1 = $urandom;
      in2 = ($urandom_range(0, 7) == 0) ? in1 : $urandom;
      sel = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 3) != 0);
      #1 chk_comb("rnd_comb");
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1 chk_regs("rnd_rst");
        rst_n = 1'b1;
      end
      tick();
      chk_regs("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_32b.md
# mux_32b

Two-input, 32-bit datapath selector used in the MIPS datapath, e.g. ALU operand B source, write-back source, or PC source. It drives a combinational output that follows the inputs within the same cycle. It also provides a registered copy of the selected word and a select-change strobe for pipeline stages that need a clock-aligned value.

## Interface
- WIDTH, 32, data width of in1, in2, dataout and dataout_q.
- RESET_VAL, 0, value loaded into dataout_q on reset.

- clk  input  1  rising-edge clock for all registered outputs.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in1  input  WIDTH  data source selected when sel=0.
- in2  input  WIDTH  data source selected when sel=1.
- sel  input  1  source select: 0 selects in1, 1 selects in2.
- en  input  1  capture enable for registered outputs; 1 loads, 0 holds.
- dataout  output  WIDTH  combinational selected word.
- dataout_q  output  WIDTH  registered selected word.
- sel_q  output  1  sel captured on the last enabled edge.
- sel_changed  output  1  one-cycle strobe: the enabled capture changed sel_q.

## Operation
- dataout = sel ? in2 : in1.
  - Purely combinational; no clock dependency.
  - Valid while rst_n=0.
- Unknown/X on sel: dataout = in1 when in1==in2, otherwise X. Do not silently pick a side.
- On each rising clk with rst_n=1 and en=1:
  - dataout_q <= dataout.
  - sel_q <= sel.
  - sel_changed <= (sel != sel_q).
- On each rising clk with rst_n=1 and en=0:
  - dataout_q and sel_q hold.
  - sel_changed <= 0.
- Width rule: no extension or truncation. Every bit i of dataout is taken from bit i of the selected input.
- No arithmetic and no internal state beyond dataout_q, sel_q and sel_changed.

## Timing
- dataout: zero-cycle latency. Settles within the same delta/combinational path after any change on in1, in2 or sel.
- dataout_q, sel_q, sel_changed: one-cycle latency from the inputs sampled at the rising clk edge.
- Reset (rst_n falling, asynchronous, takes effect immediately without a clock):
  - dataout_q = RESET_VAL.
  - sel_q = 0.
  - sel_changed = 0.
- Reset release: the first enabled edge after rst_n rises captures normally. sel_changed compares against the reset value 0, so it asserts if sel=1 on that edge.
- Reset mid-operation clears all registered outputs in the same instant. dataout is unaffected.
- Simultaneous events:
  - If sel and the selected input change together, dataout reflects the new pair.
  - The registered outputs capture whatever is stable at the edge.
- sel_changed is never asserted for two consecutive cycles unless sel toggles on consecutive enabled edges.

## Test plan
- in1=7, in2=13, sel=0 -> dataout=7. After enabled clk: dataout_q=7, sel_q=0, sel_changed=0.
- sel 0->1 with in1=7, in2=13 -> dataout=13 immediately. Next enabled clk: dataout_q=13, sel_q=1, sel_changed=1. Following clk: sel_changed=0.
- sel=1; in1=19, in2=23 -> dataout=23. in1 change alone (19->20) leaves dataout=23. After clk: dataout_q=23.
- en=0 with sel toggling and inputs changing -> dataout tracks (e.g. 7 or 13). dataout_q and sel_q hold their prior values; sel_changed=0.
- Assert rst_n=0 between clock edges while dataout_q=23 -> dataout_q=0, sel_q=0, sel_changed=0 immediately; dataout still combinational. Release with sel=1, en=1 -> first clk: sel_changed=1.
- Walking-ones on in1 with in2=~in1, both sel values -> each dataout bit matches the selected input bit for all 32 bits.
